// File: rtl/plca_rx_decode_pkg.sv
// rtl/plca_rx_decode_pkg.sv - shared codes, state and symbol types for the PLCA receive decoder
package plca_rx_decode_pkg;

    // rx_cmd encodings, identical to the transmit-side ENCODE_TXD/ENCODE_TXER values
    localparam logic [1:0] BEACON = 2'b00;
    localparam logic [1:0] COMMIT = 2'b01;
    localparam logic [1:0] NONE   = 2'b10;

    localparam logic OK    = 1'b1;
    localparam logic FAIL  = 1'b0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // RXD nibbles carried with RX_ER=1, RX_DV=0
    localparam logic [3:0] RXD_BEACON = 4'b0010;
    localparam logic [3:0] RXD_COMMIT = 4'b0011;

    localparam logic [7:0] BCN_CNT_INIT = 8'd2;
    localparam logic [7:0] BCN_CNT_MAX  = 8'd255;

    // Qualification counter values. In R_IDLE q remembers which command symbol
    // was seen once; in R_BEACON/R_COMMIT it counts one mismatching symbol.
    localparam logic [1:0] Q_NONE  = 2'd0;
    localparam logic [1:0] Q_BCN1  = 2'd1;
    localparam logic [1:0] Q_CMT1  = 2'd2;
    localparam logic [1:0] Q_MISS1 = 2'd1;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_BEACON = 2'd1,
        R_COMMIT = 2'd2,
        R_DATA   = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        SYM_DAT = 3'd0,
        SYM_BCN = 3'd1,
        SYM_CMT = 3'd2,
        SYM_IDL = 3'd3,
        SYM_OTH = 3'd4
    } sym_class_t;

    function automatic logic [1:0] cmd_of_state(input rx_state_t s);
        case (s)
            R_BEACON: cmd_of_state = BEACON;
            R_COMMIT: cmd_of_state = COMMIT;
            default:  cmd_of_state = NONE;
        endcase
    endfunction

endpackage

// File: rtl/plca_rx_sym_class.sv
// rtl/plca_rx_sym_class.sv - combinational MII receive symbol classifier
module plca_rx_sym_class
    import plca_rx_decode_pkg::*;
(
    input  logic       rx_dv,
    input  logic       rx_er,
    input  logic [3:0] rxd,
    output logic [2:0] sym_class
);

    sym_class_t cls;

    // RX_DV dominates; with RX_DV low the error flag selects idle vs command codes
    always_comb begin
        cls = SYM_OTH;
        if (rx_dv) begin
            cls = SYM_DAT;
        end else if (!rx_er) begin
            cls = SYM_IDL;
        end else if (rxd == RXD_BEACON) begin
            cls = SYM_BCN;
        end else if (rxd == RXD_COMMIT) begin
            cls = SYM_CMT;
        end
    end

    assign sym_class = cls;

endmodule

// File: rtl/plca_rx_decode.sv
// rtl/plca_rx_decode.sv - PLCA receive decoder: BEACON/COMMIT qualification from MII RX
module plca_rx_decode
    import plca_rx_decode_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       plca_reset,
    input  logic       plca_en,
    input  logic       plca_status,
    input  logic       RX_DV,
    input  logic       RX_ER,
    input  logic [3:0] RXD,
    output logic [1:0] rx_cmd,
    output logic       receiving,
    output logic       beacon_det,
    output logic [7:0] beacon_len,
    output logic       false_carrier,
    output logic [1:0] rx_state
);

    logic [2:0] cls_raw;
    sym_class_t cls;

    rx_state_t  state_q, state_d;
    logic [1:0] q_q, q_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] blen_q, blen_d;
    logic [1:0] cmd_q, cmd_d;
    logic       recv_q, recv_d;
    logic       det_q, det_d;
    logic       fc_q, fc_d;
    logic       gated;

    plca_rx_sym_class u_sym_class (
        .rx_dv     (RX_DV),
        .rx_er     (RX_ER),
        .rxd       (RXD),
        .sym_class (cls_raw)
    );

    assign cls   = sym_class_t'(cls_raw);
    assign gated = plca_reset | ~plca_en | (plca_status == FAIL);

    // Next-state, qualification counter, beacon length and output pulses
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        blen_d  = blen_q;
        fc_d    = FALSE;
        if (gated) begin
            // Abort without publishing the partial beacon length
            state_d = R_IDLE;
            q_d     = Q_NONE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    case (cls)
                        SYM_DAT: begin
                            state_d = R_DATA;
                            q_d     = Q_NONE;
                        end
                        SYM_BCN: begin
                            if (q_q == Q_BCN1) begin
                                state_d = R_BEACON;
                                q_d     = Q_NONE;
                                cnt_d   = BCN_CNT_INIT;
                            end else begin
                                q_d = Q_BCN1;
                            end
                        end
                        SYM_CMT: begin
                            if (q_q == Q_CMT1) begin
                                state_d = R_COMMIT;
                                q_d     = Q_NONE;
                            end else begin
                                q_d = Q_CMT1;
                            end
                        end
                        SYM_OTH: begin
                            q_d  = Q_NONE;
                            fc_d = TRUE;
                        end
                        default: q_d = Q_NONE;
                    endcase
                end
                R_BEACON: begin
                    if (cls == SYM_BCN) begin
                        q_d = Q_NONE;
                        if (cnt_q != BCN_CNT_MAX) begin
                            cnt_d = cnt_q + 8'd1;
                        end
                    end else if (q_q == Q_MISS1) begin
                        state_d = (cls == SYM_DAT) ? R_DATA : R_IDLE;
                        q_d     = Q_NONE;
                        blen_d  = cnt_q;
                        cnt_d   = '0;
                    end else begin
                        q_d = Q_MISS1;
                    end
                end
                R_COMMIT: begin
                    if (cls == SYM_DAT) begin
                        state_d = R_DATA;
                        q_d     = Q_NONE;
                    end else if (cls == SYM_CMT) begin
                        q_d = Q_NONE;
                    end else if (q_q == Q_MISS1) begin
                        state_d = R_IDLE;
                        q_d     = Q_NONE;
                    end else begin
                        q_d = Q_MISS1;
                    end
                end
                R_DATA: begin
                    q_d = Q_NONE;
                    if (!RX_DV) begin
                        state_d = R_IDLE;
                    end
                end
                default: begin
                    state_d = R_IDLE;
                    q_d     = Q_NONE;
                end
            endcase
        end
        det_d  = ((state_d == R_BEACON) && (state_q != R_BEACON)) ? TRUE : FALSE;
        cmd_d  = gated ? NONE : cmd_of_state(state_q);
        recv_d = RX_DV;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= R_IDLE;
            q_q     <= Q_NONE;
            cnt_q   <= '0;
            blen_q  <= '0;
            cmd_q   <= NONE;
            recv_q  <= 1'b0;
            det_q   <= 1'b0;
            fc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            blen_q  <= blen_d;
            cmd_q   <= cmd_d;
            recv_q  <= recv_d;
            det_q   <= det_d;
            fc_q    <= fc_d;
        end
    end

    assign rx_cmd        = cmd_q;
    assign receiving     = recv_q;
    assign beacon_det    = det_q;
    assign beacon_len    = blen_q;
    assign false_carrier = fc_q;
    assign rx_state      = state_q;

endmodule

// File: doc/plca_rx_decode.md
PLCA_RX_DECODE -- requirements
Module: plca_rx_decode

Interface
REQ-001 SHALL have port clk  input  1  MII receive clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port plca_reset  input  1  PLCA control reset; when 1, block held in R_IDLE.
REQ-004 SHALL have port plca_en  input  1  PLCA enable; when 0, block held in R_IDLE.
REQ-005 SHALL have port plca_status  input  1  OK=1 / FAIL=0; when FAIL, block held in R_IDLE.
REQ-006 SHALL have ports RX_DV, RX_ER  input  1 each  MII receive data valid / error.
REQ-007 SHALL have port RXD  input  4  MII receive nibble.
REQ-008 SHALL have port rx_cmd  output  2  BEACON=2'b00, COMMIT=2'b01, NONE=2'b10.
REQ-009 SHALL have port receiving  output  1  registered RX_DV.
REQ-010 SHALL have port beacon_det  output  1  one-cycle pulse on BEACON qualification.
REQ-011 SHALL have port beacon_len  output  8  length in cycles of the last completed BEACON, saturating at 255.
REQ-012 SHALL have port false_carrier  output  1  one-cycle pulse per OTHER symbol received in R_IDLE.
REQ-013 SHALL have port rx_state  output  2  current state encoding, for debug.

Function
REQ-014 SHALL classify each cycle combinationally: DAT = RX_DV=1; BCN = RX_DV=0, RX_ER=1, RXD=4'b0010; CMT = RX_DV=0, RX_ER=1, RXD=4'b0011; IDL = RX_DV=0, RX_ER=0; OTH = all other RX_DV=0 cases.
REQ-015 SHALL implement states R_IDLE=0, R_BEACON=1, R_COMMIT=2, R_DATA=3, with a 2-bit qualification counter q.
REQ-016 In R_IDLE: DAT -> R_DATA; a second consecutive BCN -> R_BEACON; a second consecutive CMT -> R_COMMIT; otherwise stay.
REQ-017 In R_BEACON: two consecutive non-BCN cycles -> R_IDLE; if the second of those is DAT -> R_DATA.
REQ-018 In R_COMMIT: DAT -> R_DATA immediately; two consecutive non-CMT, non-DAT cycles -> R_IDLE.
REQ-019 In R_DATA: RX_DV=0 -> R_IDLE; RX_DV=1 -> stay. BCN/CMT are never recognised inside R_DATA.
REQ-020 rx_cmd SHALL be registered: BEACON in R_BEACON, COMMIT in R_COMMIT, otherwise NONE. Latency is one clock after the qualifying (second) symbol edge.
REQ-021 A single glitch symbol inside R_BEACON or R_COMMIT SHALL NOT change rx_cmd; q resets on the next matching symbol.
REQ-022 beacon_det SHALL pulse on the clock on which the state becomes R_BEACON.
REQ-023 The beacon counter SHALL start at 2 on entry to R_BEACON and increment per BCN cycle, saturating at 255; it is copied to beacon_len on exit.
REQ-024 receiving SHALL equal RX_DV delayed one clock, independent of gating.
REQ-025 plca_reset=1, plca_en=0 or plca_status=FAIL SHALL force R_IDLE, rx_cmd=NONE and q=0 on the next clock, aborting any command without updating beacon_len.
REQ-026 A BCN->CMT change SHALL take effect only after two CMT cycles: first to R_IDLE via REQ-017, then qualification in R_IDLE.

Reset
REQ-027 On reset=1, regardless of clk: state=R_IDLE, q=0, rx_cmd=NONE, receiving=0, beacon_det=0, beacon_len=0, false_carrier=0, counter=0.
REQ-028 The first clock edge after reset release SHALL evaluate inputs normally.

Structure
REQ-029 BEACON/COMMIT/NONE, OK/FAIL, TRUE/FALSE and the RXD codes 4'b0010/4'b0011 SHALL come from the shared IEEE_P802_3da_param.v and mod_148_4_5_param.v includes, matching ENCODE_TXD/ENCODE_TXER.
REQ-030 Symbol classification SHALL be one combinational sub-module, plca_rx_sym_class, with 3-bit class output. The FSM, counters and registers stay in plca_rx_decode.

Verification
REQ-031 Reset mid-BEACON (reset at cycle 5) -> all outputs 0/NONE asynchronously, with beacon_len unchanged at 0.
REQ-032 20 BCN cycles then IDL -> rx_cmd=BEACON from the 3rd edge; beacon_det pulses once; beacon_len=20 after exit; rx_cmd=NONE two cycles after the first IDL.
REQ-033 CMT x4 then DAT x64 then IDL -> rx_cmd COMMIT then NONE at DAT+1; receiving=1 for 64 cycles, lagging by one.
REQ-034 BCN x300 -> beacon_len=255 on exit.
REQ-035 BCN x10 with one OTH at cycle 6 -> rx_cmd stays BEACON throughout; false_carrier stays 0.
REQ-036 plca_en dropped during COMMIT -> rx_cmd=NONE next edge; CMT with plca_en=0 never qualifies.
